decoder_nbit: RTL and testbench
===============================

DECODER_NBIT -- requirements
Module: decoder_nbit

Interface
REQ-001 Parameter N, default 3: select-input width; legal range 1..8.
REQ-002 Parameter ACTIVE_LOW, default 0: 1 inverts every bit of y at the output stage.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on rising clk edge.
REQ-005 a  input  N  binary select index, unsigned 0..2**N-1.
REQ-006 enable  input  1  decode enable; 0 forces all-inactive output.
REQ-007 in_valid  input  1  a/enable sampled only when 1.
REQ-008 y  output  2**N  registered one-hot decode (one-cold when ACTIVE_LOW=1).
REQ-009 y_valid  output  1  registered; 1 when y reflects a sampled request.
REQ-010 y_index  output  N  registered copy of the sampled a.

Function
REQ-011 Decode rule (ACTIVE_LOW=0): enable=1 SHALL give y[a]=1 and all other bits 0; enable=0 SHALL give y all 0.
REQ-012 ACTIVE_LOW=1 SHALL output the bitwise inverse of REQ-011 (enable=0 gives all 1s).
REQ-013 Latency SHALL be exactly 1 clk: inputs sampled at edge k with in_valid=1 appear on y/y_index at edge k and are visible through cycle k+1.
REQ-014 in_valid=1 at an edge SHALL load y, y_index and set y_valid=1 the same edge.
REQ-015 in_valid=0 at an edge SHALL hold y and y_index unchanged and clear y_valid to 0.
REQ-016 For enable=1, y SHALL have exactly one active bit for every a in 0..2**N-1; no out-of-range index exists (a spans exactly 2**N).
REQ-017 y_index SHALL load a even when enable=0.
REQ-018 a or enable changing while in_valid=0 SHALL have no effect on outputs.
REQ-019 Index-to-bit mapping: a=0 drives y[0] (LSB), a=2**N-1 drives y[2**N-1] (MSB).
REQ-020 No combinational path from any input to any output.

Reset
REQ-021 reset=1 at a rising edge SHALL set y to all-inactive (0s, or 1s when ACTIVE_LOW=1), y_valid=0, y_index=0.
REQ-022 Reset SHALL take priority over in_valid at the same edge.
REQ-023 Outputs SHALL be X-free from the first edge with reset=1 onward.
REQ-024 Reset asserted mid-stream SHALL discard the pending request; the first edge with reset=0 and in_valid=1 loads normally.

Structure
REQ-025 A shared package decoder_pkg SHALL hold the default width constant (3) and a function returning the all-inactive pattern for a given ACTIVE_LOW.
REQ-026 One combinational sub-module decoder_core (params N; inputs a, enable; output one-hot 2**N) SHALL perform the decode.
REQ-027 The top SHALL instantiate decoder_core once and add the polarity and register stages.

Verification
REQ-028 Reset: reset=1 for 2 edges -> y=00000000, y_valid=0, y_index=0 (N=3, ACTIVE_LOW=0).
REQ-029 Sweep: in_valid=1, enable=1, a=0..7 on successive edges -> one edge later y=00000001, 00000010, ... 10000000, with y_valid=1 each cycle.
REQ-030 Disable: in_valid=1, enable=0, a=5 -> y=00000000, y_index=5, y_valid=1.
REQ-031 Hold: load a=3, enable=1, then in_valid=0 with a=6 -> y stays 00001000, y_valid=0.
REQ-032 Reset priority: reset=1 and in_valid=1, a=7, enable=1 at the same edge -> y=00000000, y_valid=0.
REQ-033 ACTIVE_LOW=1, N=2: enable=1, a=2 -> y=1011; enable=0 -> y=1111.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared constants and helpers for the registered N-bit binary decoder.
package decoder_pkg;

  localparam int DEFAULT_N = 3;
  localparam int MAX_N     = 8;
  localparam int MAX_W     = 1 << MAX_N;

  // Idle pattern at full width; callers keep the low 2**N bits.
  function automatic logic [MAX_W-1:0] inactive_pattern(input bit active_low);
    return active_low ? {MAX_W{1'b1}} : {MAX_W{1'b0}};
  endfunction

endpackage

// File: rtl/decoder_core.sv
// Purely combinational one-hot decode of a binary index, gated by enable.
module decoder_core
  import decoder_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0]      a,
  input  logic              enable,
  output logic [(1<<N)-1:0] y
);

  localparam int W = 1 << N;

  // One comparator per output bit; a spans exactly W codes, so no range guard.
  for (genvar i = 0; i < W; i++) begin : g_bit
    localparam logic [N-1:0] IDX = N'(i);
    assign y[i] = enable && (a == IDX);
  end

endmodule

// File: rtl/decoder_nbit.sv
// Registered N-to-2**N decoder with selectable output polarity and a valid flag.
module decoder_nbit
  import decoder_pkg::*;
#(
  parameter int N          = DEFAULT_N,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      a,
  input  logic              enable,
  input  logic              in_valid,
  output logic [(1<<N)-1:0] y,
  output logic              y_valid,
  output logic [N-1:0]      y_index
);

  localparam int               W          = 1 << N;
  localparam logic [MAX_W-1:0] INACT_FULL = inactive_pattern(ACTIVE_LOW);
  localparam logic [W-1:0]     INACT      = INACT_FULL[W-1:0];

  logic [W-1:0] w_onehot;
  logic [W-1:0] w_dec;

  decoder_core #(.N(N)) u_core (
    .a      (a),
    .enable (enable),
    .y      (w_onehot)
  );

  assign w_dec = ACTIVE_LOW ? ~w_onehot : w_onehot;

  // y and y_index hold across idle cycles; only y_valid drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      y       <= INACT;
      y_valid <= 1'b0;
      y_index <= '0;
    end else if (in_valid) begin
      y       <= w_dec;
      y_valid <= 1'b1;
      y_index <= a;
    end else begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decoder_nbit.sv
// Bench for decoder_nbit: directed vector table, AL/N=2 sequence, random vs model.
module tb_decoder_nbit;

  logic       clk = 1'b0;
  logic       rst, iv, en;
  logic [2:0] a;
  logic [7:0] y;
  logic       y_valid;
  logic [2:0] y_index;

  logic       rst2, iv2, en2;
  logic [1:0] a2;
  logic [3:0] y2;
  logic       y_valid2;
  logic [1:0] y_index2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decoder_nbit #(.N(3), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .reset(rst), .a(a), .enable(en), .in_valid(iv),
    .y(y), .y_valid(y_valid), .y_index(y_index)
  );

  decoder_nbit #(.N(2), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .reset(rst2), .a(a2), .enable(en2), .in_valid(iv2),
    .y(y2), .y_valid(y_valid2), .y_index(y_index2)
  );

  typedef struct {
    string      nm;
    logic       rst, iv, en;
    logic [2:0] a;
    logic [7:0] ey;
    logic       ev;
    logic [2:0] ei;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string nm, logic r, logic v, logic e, logic [2:0] ai,
                              logic [7:0] ey, logic ev, logic [2:0] ei);
    vec_t t;
    t.nm = nm; t.rst = r; t.iv = v; t.en = e; t.a = ai;
    t.ey = ey; t.ev = ev; t.ei = ei;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model state, one per instance.
  logic [7:0] m_y;  logic m_v;  logic [2:0] m_i;
  logic [3:0] m_y2; logic m_v2; logic [1:0] m_i2;

  initial begin
    rst = 1'b1; iv = 1'b0; en = 1'b0; a = '0;
    rst2 = 1'b1; iv2 = 1'b0; en2 = 1'b0; a2 = '0;

    tbl.push_back(mk("rst0",     1, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk("rst1",     1, 0, 0, 0, 8'h00, 0, 0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk($sformatf("sweep%0d", k), 0, 1, 1, 3'(k), 8'(1 << k), 1, 3'(k)));
    tbl.push_back(mk("disable",  0, 1, 0, 5, 8'h00, 1, 5));
    tbl.push_back(mk("load3",    0, 1, 1, 3, 8'h08, 1, 3));
    tbl.push_back(mk("hold6",    0, 0, 1, 6, 8'h08, 0, 3));
    tbl.push_back(mk("hold_en0", 0, 0, 0, 1, 8'h08, 0, 3));
    tbl.push_back(mk("rstprio",  1, 1, 1, 7, 8'h00, 0, 0));
    tbl.push_back(mk("postrst",  0, 1, 1, 2, 8'h04, 1, 2));
    tbl.push_back(mk("idle",     0, 0, 0, 0, 8'h04, 0, 2));

    foreach (tbl[k]) begin
      rst = tbl[k].rst; iv = tbl[k].iv; en = tbl[k].en; a = tbl[k].a;
      step();
      chk({tbl[k].nm, ".y"},   32'(y),       32'(tbl[k].ey));
      chk({tbl[k].nm, ".vld"}, 32'(y_valid), 32'(tbl[k].ev));
      chk({tbl[k].nm, ".idx"}, 32'(y_index), 32'(tbl[k].ei));
      if (k == 0) chk("xfree", 32'($isunknown({y, y_valid, y_index})), 32'd0);
    end

    // Active-low, N=2 instance: reset value, decode, disable.
    rst2 = 1'b0; iv2 = 1'b1; en2 = 1'b1; a2 = 2'd2;
    chk("al.rst.y", 32'(y2), 32'hF);
    chk("al.rst.vld", 32'(y_valid2), 32'd0);
    step();
    chk("al.en.y", 32'(y2), 32'hB);
    chk("al.en.vld", 32'(y_valid2), 32'd1);
    chk("al.en.idx", 32'(y_index2), 32'd2);
    en2 = 1'b0;
    step();
    chk("al.dis.y", 32'(y2), 32'hF);
    chk("al.dis.idx", 32'(y_index2), 32'd2);

    // Random phase: both instances against the behavioural model.
    rst = 1'b1; rst2 = 1'b1;
    step();
    m_y = 8'h00; m_v = 0; m_i = 0;
    m_y2 = 4'hF; m_v2 = 0; m_i2 = 0;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(15) == 0); iv = 1'($urandom); en = 1'($urandom); a = 3'($urandom);
      rst2 = ($urandom_range(15) == 0); iv2 = 1'($urandom); en2 = 1'($urandom); a2 = 2'($urandom);
      if (rst) begin
        m_y = 8'h00; m_v = 0; m_i = 0;
      end else if (iv) begin
        m_y = en ? 8'(1 << a) : 8'h00; m_v = 1; m_i = a;
      end else m_v = 0;
      if (rst2) begin
        m_y2 = 4'hF; m_v2 = 0; m_i2 = 0;
      end else if (iv2) begin
        m_y2 = en2 ? ~4'(1 << a2) : 4'hF; m_v2 = 1; m_i2 = a2;
      end else m_v2 = 0;
      step();
      chk("rnd.y",      32'(y),        32'(m_y));
      chk("rnd.vld",    32'(y_valid),  32'(m_v));
      chk("rnd.idx",    32'(y_index),  32'(m_i));
      chk("rnd.al.y",   32'(y2),       32'(m_y2));
      chk("rnd.al.vld", 32'(y_valid2), 32'(m_v2));
      chk("rnd.al.idx", 32'(y_index2), 32'(m_i2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
